// File: rtl/mult_seq_if.sv
// Request/result bundle between the EX-stage control unit and the
// sequential multiplier.
//
// Handshake: start is a level request that the multiplier samples only
// while idle. A sampled start raises busy on the following cycle, and busy
// stays high until the result is written. done is a single-cycle pulse
// with busy already low. hi/lo are valid from that cycle until the next
// done pulse or reset. A start that arrives while busy is dropped, not
// queued. cancel aborts a running operation without a done pulse, and it
// also blocks a start that arrives in the same cycle.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Control unit side.
  modport master (
    output start, signed_op, cancel, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side.
  modport slave (
    input  start, signed_op, cancel, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier for MULT/MULTU.
// The unit takes the operand magnitudes and performs one conditional add
// plus one shift per cycle. A final cycle applies the sign and writes the
// product to HI/LO.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplier;   // low half of the accumulator shares this register
  logic               neg;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes, the carry adder, and the final sign correction.
  // Negating the most negative value yields the same bit pattern, which is
  // the correct unsigned magnitude. Negating zero yields zero, so -0 never
  // appears.
  always_comb begin
    a_mag  = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag  = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc_hi} + {1'b0, addend};
    prod   = {acc_hi, mplier};
    result = neg ? -prod : prod;
  end

  // Control FSM and datapath: accept in IDLE, iterate WIDTH times in RUN,
  // then write the signed result in SIGN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            neg    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            count  <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            // Shift {carry, acc_hi, mplier} right by one after the conditional add.
            acc_hi <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == LAST_ITER) begin
              state <= S_SIGN;
            end
          end
        end
        S_SIGN: begin
          if (!bus.cancel) begin
            hi_q   <= result[2*WIDTH-1:WIDTH];
            lo_q   <= result[WIDTH-1:0];
            done_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq. Results are compared against a reference model that
// uses plain 64-bit arithmetic.
module tb_mult_seq;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res = '0;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    if (s) begin
      sa = $signed(av);
      sb = $signed(bv);
      return sa * sb;
    end
    ua = {{W{1'b0}}, av};
    ub = {{W{1'b0}}, bv};
    return ua * ub;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. The task issues one operation and waits for done.
  // It returns at the negedge inside the done cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    int lat;
    logic [2*W-1:0] exp;
    lat = 0;
    bus.a = av;
    bus.b = bv;
    bus.signed_op = s;
    bus.start = 1'b1;
    exp_q.push_back(ref_mul(av, bv, s));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.signed_op = 1'($urandom_range(0, 1));
    check("busy_after_start", 64'(bus.busy), 64'(1));
    check("hold_during_run", {bus.hi, bus.lo}, last_res);
    for (int i = 1; i <= W + 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("done_latency", 64'(lat), 64'(W + 1));
    exp = exp_q.pop_front();
    if (lat != 0) begin
      check("result", {bus.hi, bus.lo}, exp);
      check("busy_low_at_done", 64'(bus.busy), 64'(0));
      last_res = exp;
    end
  endtask

  // Waits n cycles and returns the number of done pulses seen.
  task automatic count_done(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
  endtask

  // Starts an operation and raises cancel so that it is sampled at edge k
  // after the accepting edge. k = W+1 lands on the sign cycle.
  task automatic cancel_at(input int k);
    int dones;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.signed_op = 1'($urandom_range(0, 1));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (k - 1) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'(0));
    check("cancel_done", 64'(bus.done), 64'(0));
    check("cancel_hold", {bus.hi, bus.lo}, last_res);
    count_done(W + 6, dones);
    check("cancel_no_done", 64'(dones), 64'(0));
    check("cancel_hold_later", {bus.hi, bus.lo}, last_res);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edges[5];
    edges[0] = '0;
    edges[1] = 32'h1;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'hFFFF_FFFF;
    edges[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  logic [W-1:0] dir_a[9];
  logic [W-1:0] dir_b[9];
  logic         dir_s[9];

  initial begin
    int dones;
    logic [2*W-1:0] exp;
    logic [2*W-1:0] seen_res;

    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.cancel = 1'b0;
    bus.a = '0;
    bus.b = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_hilo", {bus.hi, bus.lo}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations, including the signed corner cases.
    dir_a[0] = 32'd100;        dir_b[0] = 32'd123;        dir_s[0] = 1'b0;
    dir_a[1] = 32'h7FFF_FFFF;  dir_b[1] = 32'd3;          dir_s[1] = 1'b0;
    dir_a[2] = 32'hFFFF_FFFF;  dir_b[2] = 32'hFFFF_FFFF;  dir_s[2] = 1'b0;
    dir_a[3] = 32'hFFFF_FFFF;  dir_b[3] = 32'hFFFF_FFFF;  dir_s[3] = 1'b1;
    dir_a[4] = 32'hFFFF_FFFE;  dir_b[4] = 32'd3;          dir_s[4] = 1'b1;
    dir_a[5] = 32'h8000_0000;  dir_b[5] = 32'h8000_0000;  dir_s[5] = 1'b1;
    dir_a[6] = 32'd0;          dir_b[6] = 32'hFFFF_FFFB;  dir_s[6] = 1'b1;
    dir_a[7] = 32'h8000_0000;  dir_b[7] = 32'd1;          dir_s[7] = 1'b1;
    dir_a[8] = 32'h1234_5678;  dir_b[8] = 32'h8765_4321;  dir_s[8] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_op(dir_a[i], dir_b[i], dir_s[i]);
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'(0));
    end

    // Hand-computed values for the first cases, independent of the model.
    run_op(32'd100, 32'd123, 1'b0);
    check("multu_100x123", {bus.hi, bus.lo}, 64'h0000_0000_0000_300C);
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1);
    check("mult_m2x3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("mult_min_sq", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);

    // A start while busy is ignored and not queued.
    exp = ref_mul(32'd5, 32'd7, 1'b0);
    bus.a = 32'd5;
    bus.b = 32'd7;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 32'd9;
    bus.b = 32'hFFFF_FFF0;
    bus.signed_op = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    seen_res = '0;
    for (int i = 0; i < W + 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        seen_res = {bus.hi, bus.lo};
      end
    end
    check("ignored_start_dones", 64'(dones), 64'(1));
    check("ignored_start_result", seen_res, exp);
    last_res = exp;

    // A back-to-back start in the done cycle is accepted.
    run_op(32'd11, 32'd13, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1);
    @(negedge clk);

    // Cancel in the middle of the run, and cancel in the sign cycle.
    cancel_at(10);
    cancel_at(W + 1);

    // In idle, cancel takes priority over start.
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_prio_busy", 64'(bus.busy), 64'(0));
    count_done(W + 6, dones);
    check("cancel_prio_no_done", 64'(dones), 64'(0));

    // Randomized operations with random idle gaps; a gap of 0 is back-to-back.
    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);

    // An asynchronous reset in the middle of an operation.
    bus.a = $urandom;
    bus.b = $urandom;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_done", 64'(bus.done), 64'(0));
    check("async_rst_hilo", {bus.hi, bus.lo}, '0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    count_done(W + 6, dones);
    check("post_rst_no_done", 64'(dones), 64'(0));
    run_op(32'd100, 32'd123, 1'b0);
    check("post_rst_op", {bus.hi, bus.lo}, 64'h0000_0000_0000_300C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
